// File: rtl/if_id_fetch_stage_pkg.sv
// rtl/if_id_fetch_stage_pkg.sv - shared widths, reset constants and fetch FSM encoding
package if_id_fetch_stage_pkg;

    localparam int ADDR_BITS  = 32;
    localparam int INSTR_BITS = 32;

    localparam logic [ADDR_BITS-1:0]  RESET_PC  = '0;
    localparam logic [INSTR_BITS-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// rtl/if_id_fetch_stage_if.sv - instruction memory request/response bus
interface if_id_fetch_stage_if #(
    parameter int ADDR_BITS  = if_id_fetch_stage_pkg::ADDR_BITS,
    parameter int INSTR_BITS = if_id_fetch_stage_pkg::INSTR_BITS
) ();

    logic                  imem_req;
    logic [ADDR_BITS-1:0]  imem_addr;
    logic                  imem_ready;
    logic [INSTR_BITS-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_id_fetch_stage_skid_buffer.sv
// rtl/if_id_fetch_stage_skid_buffer.sv - one-entry holding register for a response taken under hold
module if_skid_buffer #(
    parameter int ADDR_BITS  = if_id_fetch_stage_pkg::ADDR_BITS,
    parameter int INSTR_BITS = if_id_fetch_stage_pkg::INSTR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drop,
    input  logic [INSTR_BITS-1:0] load_instr,
    input  logic [ADDR_BITS-1:0]  load_pc,
    output logic                  valid,
    output logic [INSTR_BITS-1:0] instr,
    output logic [ADDR_BITS-1:0]  pc
);

    logic                  valid_q, valid_d;
    logic [INSTR_BITS-1:0] instr_q, instr_d;
    logic [ADDR_BITS-1:0]  pc_q, pc_d;

    // drop wins so a redirect or delivery in the same cycle never leaves a stale entry
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (drop) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - MIPS fetch stage: PC, fetch FSM, skid entry and IF/ID register
// Optional saturating performance counters when FETCH_PERF_CNT_EN is defined.
module if_id_fetch_stage #(
    parameter int                    ADDR_BITS  = if_id_fetch_stage_pkg::ADDR_BITS,
    parameter int                    INSTR_BITS = if_id_fetch_stage_pkg::INSTR_BITS,
    parameter logic [ADDR_BITS-1:0]  RESET_PC   = if_id_fetch_stage_pkg::RESET_PC,
    parameter logic [INSTR_BITS-1:0] NOP_INSTR  = if_id_fetch_stage_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  branch_taken,
    input  logic [ADDR_BITS-1:0]  branch_target,
    if_id_fetch_stage_if.master   imem,
    output logic [ADDR_BITS-1:0]  pc,
    output logic [INSTR_BITS-1:0] if_id_instr,
    output logic [ADDR_BITS-1:0]  if_id_pc4,
    output logic                  if_id_valid,
    output logic                  fetch_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_hold_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    import if_id_fetch_stage_pkg::*;

    localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(4);

    fetch_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0]  pc_q, pc_d;
    logic [INSTR_BITS-1:0] instr_q, instr_d;
    logic [ADDR_BITS-1:0]  pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic                  stall_q, stall_d;
    logic                  req_q, req_d;

    logic                  redirect, stall_evt;
    logic                  skid_load, skid_drop, skid_valid;
    logic [INSTR_BITS-1:0] skid_instr;
    logic [ADDR_BITS-1:0]  skid_pc;

    assign redirect = branch_taken & ~hold;

    if_skid_buffer #(.ADDR_BITS(ADDR_BITS), .INSTR_BITS(INSTR_BITS)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drop       (skid_drop),
        .load_instr (imem.imem_rdata),
        .load_pc    (pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        stall_evt = 1'b0;
        if (redirect) begin
            pc_d      = branch_target;
            instr_d   = NOP_INSTR;
            pc4_d     = '0;
            valid_d   = 1'b0;
            stall_d   = 1'b0;
            skid_drop = 1'b1;
            state_d   = (req_q && !imem.imem_ready) ? ST_DISCARD : ST_FETCH;
        end else if (state_q == ST_DISCARD) begin
            // the stale response is consumed even under hold so it cannot be mistaken for the target
            if (imem.imem_ready) state_d = ST_FETCH;
        end else if (hold) begin
            skid_load = (state_q == ST_FETCH) && imem.imem_ready && !skid_valid;
        end else if (state_q == ST_BOOT) begin
            state_d = ST_FETCH;
        end else if (skid_valid) begin
            instr_d   = skid_instr;
            pc4_d     = skid_pc + PC_STEP;
            valid_d   = 1'b1;
            stall_d   = 1'b0;
            pc_d      = skid_pc + PC_STEP;
            skid_drop = 1'b1;
        end else if (imem.imem_ready) begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_q + PC_STEP;
            valid_d = 1'b1;
            stall_d = 1'b0;
            pc_d    = pc_q + PC_STEP;
        end else begin
            instr_d   = NOP_INSTR;
            pc4_d     = '0;
            valid_d   = 1'b0;
            stall_d   = 1'b1;
            stall_evt = 1'b1;
        end
        req_d = (state_d != ST_BOOT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            req_q   <= req_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc4      = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_stall    = stall_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_evt ? sat_inc32(stall_cnt_q) : stall_cnt_q;
        hold_cnt_d  = hold      ? sat_inc32(hold_cnt_q)  : hold_cnt_q;
        flush_cnt_d = redirect  ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            hold_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_hold_cnt  = hold_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
